mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute unit.
- Consumes the ALU result (used as the effective address or as a pass-through value), the store operand, the destination register and the conditional write enable.
- Performs loads and stores to data memory over a req/ack handshake and produces registered writeback data for the register file.
- Back-pressures the pipeline while a memory access is outstanding.

Parameters:
- DMEM_AW, 32, width of the byte address presented to data memory.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute stage presents an instruction
- in_ready  output  1  stage can accept an instruction this cycle
- stall  output  1  in_valid & ~in_ready; freezes upstream stages
- memop  input  4  memory operation code (`memop_bit)
- alu_result  input  32  execute result; effective address for loads/stores
- store_data  input  32  register operand rdata2 for stores
- wreg_addr  input  5  destination register
- reg_wr_en  input  1  condition-qualified write enable from execute
- dmem_req  output  1  memory request, held until acknowledged
- dmem_we  output  1  1 = store
- dmem_addr  output  DMEM_AW  word-aligned address, bits [1:0] = 0
- dmem_be  output  4  byte enables, bit i = byte lane i (little-endian)
- dmem_wdata  output  32  lane-replicated store data
- dmem_ack  input  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  input  32  load word
- out_valid  output  1  one-cycle pulse: writeback fields are valid
- wb_data  output  32  writeback value
- wb_addr  output  5  writeback register
- wb_en  output  1  register-file write strobe, qualified by out_valid

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - dmem_req, dmem_we, out_valid, wb_en = 0.
  - dmem_addr, dmem_be, dmem_wdata, wb_data, wb_addr = 0.
  - Reset mid-access abandons the access. A dmem_ack arriving while in IDLE is ignored.
- FSM has two states, IDLE and ACCESS.
- in_ready = (state==IDLE).
- Accept condition is in_valid & in_ready at a rising edge. On accept, the request fields are latched.
- Non-memory op (memop=NONE):
  - Stay in IDLE.
  - Next cycle: out_valid=1, wb_data=alu_result, wb_en=reg_wr_en. Latency is 1.
- Load/store op:
  - Go to ACCESS.
  - Next cycle: dmem_req=1, with dmem_addr={addr[31:2],2'b00}.
  - dmem_req and all dmem_* outputs stay stable until dmem_ack is sampled high.
  - On ack: go to IDLE and clear dmem_req.
  - The cycle after ack: out_valid=1. Minimum latency is 2 (ack in the first request cycle).
- Stores:
  - SB: dmem_be=4'b0001<<addr[1:0], dmem_wdata={4{sd[7:0]}}.
  - SH: dmem_be=addr[1]?4'b1100:4'b0011, dmem_wdata={2{sd[15:0]}}.
  - SW: dmem_be=4'b1111.
  - Result for all stores: out_valid=1, wb_en=0.
- Loads:
  - Lane select by addr[1:0] (LB/LBU) or addr[1] (LH/LHU).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - For loads dmem_be=4'b1111.
  - wb_en=reg_wr_en. A load with reg_wr_en=0 still performs the access.
- out_valid is high for exactly one cycle per accepted instruction. No downstream backpressure.
- Back-to-back: an instruction may be accepted in the same edge that out_valid rises for the previous one (IDLE→IDLE). After an ack, in_ready is high in the following cycle.
- Misalignment without the feature:
  - Half accesses ignore addr[0].
  - Word accesses ignore addr[1:0].
- Unknown memop codes are treated as NONE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output exc_misalign (1 bit, reset 0), asserted together with out_valid.
  - An access is misaligned when LH/LHU/SH has addr[0]=1, or LW/SW has addr[1:0]!=0.
  - A misaligned access never reaches ACCESS: no dmem_req is issued, out_valid pulses next cycle with wb_en=0 and exc_misalign=1.
- Undefined:
  - Port absent.
  - Low address bits ignored as described above.

Decomposition:
- definations.vh gains the following:
  - `memop_bit` ([3:0]).
  - Encodings `memop_none`=0, `memop_lb`=1, `memop_lbu`=2, `memop_lh`=3, `memop_lhu`=4, `memop_lw`=5, `memop_sb`=6, `memop_sh`=7, `memop_sw`=8.
  - FSM state constants.
- One sub-module, load_align: combinational lane extract plus sign/zero extension from (memop, addr[1:0], rdata).

Test Plan:
- NONE, alu_result=32'h1234_5678, reg_wr_en=1, wreg_addr=5 -> next cycle out_valid=1, wb_data=32'h12345678, wb_en=1, wb_addr=5, no dmem_req.
- SB to addr 32'h0000_0103, store_data=32'hAABBCCDD; ack after 3 cycles -> dmem_addr=32'h100, dmem_be=4'b1000, dmem_wdata=32'hDDDDDDDD, req held 3 cycles, stall high throughout, out_valid with wb_en=0.
- LB addr 32'h102, rdata=32'h0080_0000, ack immediate -> wb_data=32'hFFFFFF80; same with LBU -> 32'h00000080; LH addr 32'h102 rdata=32'h8001_0000 -> 32'hFFFF8001.
- Back-to-back LW (ack delayed 2) then NONE -> second accepted the cycle after ack, two out_valid pulses in order, correct wb_addr each.
- rst_n low while dmem_req=1 -> dmem_req=0 immediately; a later stray dmem_ack produces no out_valid.
- With MEM_ALIGN_CHECK_EN, LW addr 32'h102 -> no dmem_req, next cycle out_valid=1, exc_misalign=1, wb_en=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: memory-op encodings, FSM state constants and store lane helpers for mem_stage.
`default_nettype none

package mem_stage_pkg;

  localparam logic [3:0] MEMOP_NONE = 4'd0;
  localparam logic [3:0] MEMOP_LB   = 4'd1;
  localparam logic [3:0] MEMOP_LBU  = 4'd2;
  localparam logic [3:0] MEMOP_LH   = 4'd3;
  localparam logic [3:0] MEMOP_LHU  = 4'd4;
  localparam logic [3:0] MEMOP_LW   = 4'd5;
  localparam logic [3:0] MEMOP_SB   = 4'd6;
  localparam logic [3:0] MEMOP_SH   = 4'd7;
  localparam logic [3:0] MEMOP_SW   = 4'd8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      MEMOP_SB: store_be = 4'b0001 << lo;
      MEMOP_SH: store_be = lo[1] ? 4'b1100 : 4'b0011;
      default:  store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] sd);
    case (op)
      MEMOP_SB: store_wdata = {4{sd[7:0]}};
      MEMOP_SH: store_wdata = {2{sd[15:0]}};
      default:  store_wdata = sd;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// load_align: extracts the addressed byte/half lane of a load word and sign/zero extends it.
`default_nettype none

module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  memop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (memop)
      MEMOP_LB:  data = {{24{lane_b[7]}}, lane_b};
      MEMOP_LBU: data = {24'h0, lane_b};
      MEMOP_LH:  data = {{16{lane_h[15]}}, lane_h};
      MEMOP_LHU: data = {16'h0, lane_h};
      default:   data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with req/ack data-memory handshake and registered writeback.
// Optional MEM_ALIGN_CHECK_EN adds exc_misalign and suppresses misaligned accesses.
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               stall,
  input  logic [3:0]         memop,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        store_data,
  input  logic [4:0]         wreg_addr,
  input  logic               reg_wr_en,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic               exc_misalign,
`endif
  output logic               out_valid,
  output logic [31:0]        wb_data,
  output logic [4:0]         wb_addr,
  output logic               wb_en
);

  logic [0:0]  state;
  logic [3:0]  op_q;
  logic [1:0]  lo_q;
  logic [4:0]  wreg_q;
  logic        wen_q;
  logic        is_load, is_store, is_mem, misalign, accept;
  logic        q_is_store;
  logic [31:0] load_data;

  assign in_ready = (state == ST_IDLE);
  assign stall    = in_valid & ~in_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    is_load  = (memop >= MEMOP_LB) && (memop <= MEMOP_LW);
    is_store = (memop >= MEMOP_SB) && (memop <= MEMOP_SW);
    is_mem   = is_load | is_store;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = (((memop == MEMOP_LH) || (memop == MEMOP_LHU) || (memop == MEMOP_SH)) && alu_result[0])
             | (((memop == MEMOP_LW) || (memop == MEMOP_SW)) && (alu_result[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    q_is_store = (op_q >= MEMOP_SB) && (op_q <= MEMOP_SW);
  end

  load_align u_load_align (
    .memop   (op_q),
    .addr_lo (lo_q),
    .rdata   (dmem_rdata),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'h0;
      dmem_wdata <= 32'h0;
      out_valid  <= 1'b0;
      wb_data    <= 32'h0;
      wb_addr    <= 5'h0;
      wb_en      <= 1'b0;
      op_q       <= MEMOP_NONE;
      lo_q       <= 2'b00;
      wreg_q     <= 5'h0;
      wen_q      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      exc_misalign <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      exc_misalign <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mem && !misalign) begin
              state      <= ST_ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {alu_result[DMEM_AW-1:2], 2'b00};
              dmem_be    <= store_be(memop, alu_result[1:0]);
              dmem_wdata <= is_store ? store_wdata(memop, store_data) : 32'h0;
              op_q       <= memop;
              lo_q       <= alu_result[1:0];
              wreg_q     <= wreg_addr;
              wen_q      <= reg_wr_en;
            end else begin
              // Pass-through, unknown op, or suppressed misaligned access
              out_valid <= 1'b1;
              wb_data   <= alu_result;
              wb_addr   <= wreg_addr;
              wb_en     <= reg_wr_en & ~misalign;
`ifdef MEM_ALIGN_CHECK_EN
              exc_misalign <= misalign;
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            state     <= ST_IDLE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            out_valid <= 1'b1;
            wb_data   <= q_is_store ? 32'h0 : load_data;
            wb_addr   <= wreg_q;
            wb_en     <= wen_q & ~q_is_store;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural model.
`default_nettype none

module tb_mem_stage;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, stall;
  logic [3:0]  memop = 4'd0;
  logic [31:0] alu_result = 32'h0, store_data = 32'h0;
  logic [4:0]  wreg_addr = 5'h0;
  logic        reg_wr_en = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        out_valid, wb_en;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
`ifdef MEM_ALIGN_CHECK_EN
  logic        exc_misalign;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .memop(memop), .alu_result(alu_result), .store_data(store_data), .wreg_addr(wreg_addr),
    .reg_wr_en(reg_wr_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
`ifdef MEM_ALIGN_CHECK_EN
    .exc_misalign(exc_misalign),
`endif
    .out_valid(out_valid), .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en)
  );

  // ---------------- reference model ----------------
  function automatic bit m_load(input logic [3:0] op);
    return op >= OP_LB && op <= OP_LW;
  endfunction
  function automatic bit m_store(input logic [3:0] op);
    return op >= OP_SB && op <= OP_SW;
  endfunction
  function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (a % 2 != 0)) return 1'b1;
    if ((op == OP_LW || op == OP_SW) && (a % 4 != 0)) return 1'b1;
`endif
    return 1'b0;
  endfunction
  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    if (op == OP_SB) return 4'(1 << (a % 4));
    if (op == OP_SH) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
    if (op == OP_SB) return (sd % 256) * 32'h0101_0101;
    if (op == OP_SH) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction
  function automatic logic [31:0] m_load_val(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) % 256;
    h = (rd >> (16 * ((a / 2) % 2))) % 65536;
    case (op)
      OP_LB:   return (b >= 128) ? b - 32'd256 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h - 32'd65536 : h;
      OP_LHU:  return h;
      default: return rd;
    endcase
  endfunction

  // Presents one instruction (called #1 after a rising edge), completes it with an ack after
  // d request cycles, and checks the writeback. Returns #1 after the edge where out_valid rose.
  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] wr, input logic we,
                       input int d, input logic [31:0] rd);
    bit access;
    logic [31:0] exp_wb;
    logic exp_en;
    access = (m_load(op) || m_store(op)) && !m_mis(op, a);
    in_valid = 1'b1; memop = op; alu_result = a; store_data = sd; wreg_addr = wr; reg_wr_en = we;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready before accept: got %b want 1", nm, in_ready);
    end
    @(posedge clk); #1;
    if (access) begin
      for (int i = 1; i <= d; i++) begin
        total++;
        if (dmem_req !== 1'b1 || dmem_addr !== (a & 32'hFFFF_FFFC) || dmem_be !== m_be(op, a) ||
            dmem_we !== m_store(op) || stall !== 1'b1 || out_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s req cycle %0d: req=%b addr=%h be=%b we=%b stall=%b ov=%b want 1 %h %b %b 1 0",
                   nm, i, dmem_req, dmem_addr, dmem_be, dmem_we, stall, out_valid,
                   a & 32'hFFFF_FFFC, m_be(op, a), m_store(op));
        end
        if (m_store(op)) begin
          total++;
          if (dmem_wdata !== m_wdata(op, sd)) begin
            bad++; $display("FAIL %s wdata: got %h want %h", nm, dmem_wdata, m_wdata(op, sd));
          end
        end
        if (i == d) begin dmem_ack = 1'b1; dmem_rdata = rd; end
        else dmem_rdata = $urandom;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
    end
    exp_en = m_store(op) || m_mis(op, a) ? 1'b0 : we;
    exp_wb = m_load(op) ? m_load_val(op, a, rd) : a;
    total++;
    if (out_valid !== 1'b1 || wb_en !== exp_en || wb_addr !== wr || dmem_req !== 1'b0 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s result: ov=%b en=%b waddr=%0d req=%b rdy=%b want 1 %b %0d 0 1",
               nm, out_valid, wb_en, wb_addr, dmem_req, in_ready, exp_en, wr);
    end
    if (!m_store(op) && !m_mis(op, a)) begin
      total++;
      if (wb_data !== exp_wb) begin
        bad++; $display("FAIL %s wb_data: got %h want %h", nm, wb_data, exp_wb);
      end
    end
`ifdef MEM_ALIGN_CHECK_EN
    total++;
    if (exc_misalign !== m_mis(op, a)) begin
      bad++; $display("FAIL %s exc_misalign: got %b want %b", nm, exc_misalign, m_mis(op, a));
    end
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #22;
    total++;
    if (dmem_req !== 0 || dmem_we !== 0 || out_valid !== 0 || wb_en !== 0 || dmem_addr !== 0 ||
        dmem_be !== 0 || dmem_wdata !== 0 || wb_data !== 0 || wb_addr !== 0 || in_ready !== 1) begin
      bad++;
      $display("FAIL reset values: req=%b we=%b ov=%b en=%b addr=%h be=%b wd=%h wb=%h wa=%0d rdy=%b want zeros, rdy=1",
               dmem_req, dmem_we, out_valid, wb_en, dmem_addr, dmem_be, dmem_wdata, wb_data, wb_addr, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_none;
    issue("none", OP_NONE, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 1, 32'h0);
    total++;
    @(posedge clk); #1;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL none pulse width: out_valid=%b want 0", out_valid);
    end
    issue("unknown_op", 4'd12, 32'hCAFE_0001, 32'h0, 5'd9, 1'b1, 1, 32'h0);
  endtask

  task automatic test_store;
    issue("sb_0x103", OP_SB, 32'h0000_0103, 32'hAABB_CCDD, 5'd3, 1'b1, 3, 32'h0);
    issue("sh_0x102", OP_SH, 32'h0000_0102, 32'h1122_3344, 5'd4, 1'b1, 1, 32'h0);
    issue("sw_0x200", OP_SW, 32'h0000_0200, 32'hDEAD_BEEF, 5'd6, 1'b1, 2, 32'h0);
  endtask

  task automatic test_load;
    issue("lb_neg", OP_LB, 32'h102, 32'h0, 5'd7, 1'b1, 1, 32'h0080_0000);
    issue("lbu", OP_LBU, 32'h102, 32'h0, 5'd8, 1'b1, 1, 32'h0080_0000);
    issue("lh_neg", OP_LH, 32'h102, 32'h0, 5'd10, 1'b1, 1, 32'h8001_0000);
    issue("lhu_lo", OP_LHU, 32'h100, 32'h0, 5'd11, 1'b1, 2, 32'h1234_F00D);
    issue("lw_nowen", OP_LW, 32'h104, 32'h0, 5'd12, 1'b0, 1, 32'h5555_AAAA);
  endtask

  task automatic test_back_to_back;
    issue("b2b_lw", OP_LW, 32'h300, 32'h0, 5'd13, 1'b1, 2, 32'h0BAD_F00D);
    issue("b2b_none", OP_NONE, 32'h0000_0777, 32'h0, 5'd14, 1'b1, 1, 32'h0);
    issue("b2b_none2", OP_NONE, 32'h0000_0888, 32'h0, 5'd15, 1'b1, 1, 32'h0);
  endtask

  task automatic test_misalign;
    issue("lw_0x102", OP_LW, 32'h102, 32'h0, 5'd16, 1'b1, 1, 32'h8765_4321);
    issue("sh_0x101", OP_SH, 32'h101, 32'hABCD_1234, 5'd17, 1'b1, 1, 32'h0);
  endtask

  task automatic test_reset_mid_access;
    in_valid = 1'b1; memop = OP_SW; alu_result = 32'h40; store_data = 32'h1; wreg_addr = 5'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (dmem_req !== 1'b1) begin
      bad++; $display("FAIL midreset setup: dmem_req=%b want 1", dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset async: req=%b rdy=%b want 0 1", dmem_req, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    total++;
    if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL stray ack: ov=%b req=%b want 0 0", out_valid, dmem_req);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL stray ack later: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_random;
    logic [3:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 10));
      issue("random", op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(1, 4), $urandom);
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset;
    test_none;
    test_store;
    test_load;
    test_back_to_back;
    test_misalign;
    test_reset_mid_access;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
